// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: multi-cycle 32x32 multiply / 32/32 divide controller.
// It drives the shared 32-bit EX-stage ALU with one add or subtract per cycle.
//
// Ports:
//   clk, rst (synchronous, active-high)
//   start/op/a/b            request, accepted only in IDLE
//                           op[0]: 0 = multiply, 1 = divide; op[1]: signed
//   busy, done              busy while iterating; done is a one-cycle pulse
//   result_lo/result_hi     product[31:0]/[63:32], or quotient/remainder
//   div_by_zero             raised together with done when the divisor was 0
//   alu_en/alu_mode/alu_op1/alu_op2  ALU request, owned while alu_en=1
//   alu_out                 combinational ALU result in the same cycle
//
// Optional feature: define SIGNED_OPS_EN to honour op[1] (signed operands,
// fixed up in a one-cycle FIX state). Without it every op is unsigned.
module mul_div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        div_by_zero,
  output logic        alu_en,
  output logic [3:0]  alu_mode,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic [31:0] alu_out
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;
  localparam int unsigned MW = 4;
  localparam logic [MW-1:0] MODE_ADD  = 4'b0000;
  localparam logic [MW-1:0] MODE_SUB  = 4'b0001;
  localparam logic [W-1:0]  DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [CW-1:0] LAST_ITER = 5'd31;

`ifdef SIGNED_OPS_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_MUL = 3'd1, S_DIV = 3'd2, S_DONE = 3'd3, S_FIX = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_MUL = 3'd1, S_DIV = 3'd2, S_DONE = 3'd3
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Working registers: hi = acc/rem, lo = mq/quo, opnd = mcand/dvs.
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  opnd_q, opnd_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  res_lo_q, res_lo_d;
  logic [W-1:0]  res_hi_q, res_hi_d;
  logic          dbz_q, dbz_d;
  logic          alu_en_q, alu_en_d;
  logic [MW-1:0] alu_mode_q, alu_mode_d;
  logic [W-1:0]  alu_op1_q, alu_op1_d;
  logic [W-1:0]  alu_op2_q, alu_op2_d;

  logic [W-1:0]  a_mag, b_mag;
  logic [W-1:0]  mul_s;
  logic          mul_c;
  logic [W-1:0]  div_r;
  logic          div_ge;

`ifdef SIGNED_OPS_EN
  logic          sgn_q, sgn_d;
  logic          is_div_q, is_div_d;
  logic          neg_q_q, neg_q_d;   // negate quotient / product
  logic          neg_r_q, neg_r_d;   // negate remainder
  logic [2*W-1:0] prod_neg;
`else
  logic          op_signed_unused;
  assign op_signed_unused = op[1];
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    a_mag    = a;
    b_mag    = b;
    mul_s    = '0;
    mul_c    = 1'b0;
    div_r    = '0;
    div_ge   = 1'b0;
`ifdef SIGNED_OPS_EN
    sgn_d    = sgn_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    prod_neg = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef SIGNED_OPS_EN
          sgn_d    = op[1];
          is_div_d = op[0];
          neg_q_d  = a[31] ^ b[31];
          neg_r_d  = a[31];
          if (op[1] && a[31]) a_mag = (~a) + 32'd1;
          if (op[1] && b[31]) b_mag = (~b) + 32'd1;
`endif
          dbz_d  = 1'b0;
          cnt_d  = '0;
          hi_d   = '0;
          lo_d   = a_mag;
          opnd_d = b_mag;
          if (!op[0]) begin
            state_d = S_MUL;
          end else if (b == '0) begin
            // Zero divisor short-circuits to DONE with the fixed result.
            state_d  = S_DONE;
            res_lo_d = DIV0_QUOT;
            res_hi_d = a;
            dbz_d    = 1'b1;
          end else begin
            state_d = S_DIV;
          end
        end
      end

      S_MUL: begin
        if (lo_q[0]) begin
          mul_s = alu_out;
          mul_c = (alu_out < hi_q);
        end else begin
          mul_s = hi_q;
          mul_c = 1'b0;
        end
        // {c,s,mq} >> 1, keeping the low 64 bits.
        hi_d  = {mul_c, mul_s[W-1:1]};
        lo_d  = {mul_s[0], lo_q[W-1:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d  = S_DONE;
          res_hi_d = hi_d;
          res_lo_d = lo_d;
`ifdef SIGNED_OPS_EN
          if (sgn_q) begin
            state_d  = S_FIX;
            res_hi_d = res_hi_q;
            res_lo_d = res_lo_q;
          end
`endif
        end
      end

      S_DIV: begin
        div_r = {hi_q[W-2:0], lo_q[W-1]};
        // A set rem[31] means the shifted value exceeds 32 bits, so it is >= dvs.
        div_ge = hi_q[W-1] | (div_r >= opnd_q);
        hi_d   = div_ge ? alu_out : div_r;
        lo_d   = {lo_q[W-2:0], div_ge};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d  = S_DONE;
          res_hi_d = hi_d;
          res_lo_d = lo_d;
`ifdef SIGNED_OPS_EN
          if (sgn_q) begin
            state_d  = S_FIX;
            res_hi_d = res_hi_q;
            res_lo_d = res_lo_q;
          end
`endif
        end
      end

`ifdef SIGNED_OPS_EN
      S_FIX: begin
        state_d = S_DONE;
        if (is_div_q) begin
          res_lo_d = neg_q_q ? (~lo_q) + 32'd1 : lo_q;
          res_hi_d = neg_r_q ? (~hi_q) + 32'd1 : hi_q;
        end else begin
          prod_neg = (~{hi_q, lo_q}) + 64'd1;
          res_hi_d = neg_q_q ? prod_neg[2*W-1:W] : hi_q;
          res_lo_d = neg_q_q ? prod_neg[W-1:0]   : lo_q;
        end
      end
`endif

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered outputs follow the state being entered.
    busy_d     = (state_d == S_MUL) || (state_d == S_DIV)
`ifdef SIGNED_OPS_EN
                 || (state_d == S_FIX)
`endif
                 ;
    done_d     = (state_d == S_DONE);
    alu_en_d   = (state_d == S_MUL) || (state_d == S_DIV);
    alu_mode_d = (state_d == S_DIV) ? MODE_SUB : MODE_ADD;
    alu_op1_d  = '0;
    alu_op2_d  = '0;
    if (state_d == S_MUL) begin
      alu_op1_d = hi_d;
      alu_op2_d = opnd_d;
    end else if (state_d == S_DIV) begin
      alu_op1_d = {hi_d[W-2:0], lo_d[W-1]};
      alu_op2_d = opnd_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_lo_q   <= '0;
      res_hi_q   <= '0;
      dbz_q      <= 1'b0;
      alu_en_q   <= 1'b0;
      alu_mode_q <= MODE_ADD;
      alu_op1_q  <= '0;
      alu_op2_q  <= '0;
`ifdef SIGNED_OPS_EN
      sgn_q      <= 1'b0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_lo_q   <= res_lo_d;
      res_hi_q   <= res_hi_d;
      dbz_q      <= dbz_d;
      alu_en_q   <= alu_en_d;
      alu_mode_q <= alu_mode_d;
      alu_op1_q  <= alu_op1_d;
      alu_op2_q  <= alu_op2_d;
`ifdef SIGNED_OPS_EN
      sgn_q      <= sgn_d;
      is_div_q   <= is_div_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;
  assign alu_en      = alu_en_q;
  assign alu_mode    = alu_mode_q;
  assign alu_op1     = alu_op1_q;
  assign alu_op2     = alu_op2_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Scoreboard bench for mul_div_sequencer with a behavioural add/sub ALU.
module tb_mul_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero, alu_en;
  logic [31:0] result_lo, result_hi, alu_op1, alu_op2, alu_out;
  logic [3:0]  alu_mode;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_pushed = 0;
  int n_done = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  mul_div_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div_by_zero(div_by_zero), .alu_en(alu_en), .alu_mode(alu_mode),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_out(alu_out)
  );

  // Shared EX-stage ALU: add for mode 0000, subtract for 0001.
  assign alu_out = (alu_mode == 4'b0001) ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_lo", 64'(result_lo), 64'(e.lo));
        chk("result_hi", 64'(result_hi), 64'(e.hi));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input bit push, input logic [31:0] elo, input logic [31:0] ehi,
                       input logic edbz, input int lat, output int c0);
    exp_t e;
    @(negedge clk);
    c0 = cyc;
    op = o; a = va; b = vb; start = 1'b1;
    if (push) begin
      e.lo = elo; e.hi = ehi; e.dbz = edbz; e.cyc = c0 + lat;
      sb.push_back(e);
      n_pushed++;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=pending%0d expected=none", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Counts busy, alu_en and non-add-mode cycles over n sampled cycles.
  task automatic watch(input int n, output int nb, output int ne, output int nm);
    nb = 0; ne = 0; nm = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) begin
        nb++;
        if (alu_mode != 4'b0000) nm++;
      end
      if (alu_en) ne++;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, div_by_zero, alu_en, alu_mode}), 64'd0);
    chk({tag, "_res"}, {result_hi, result_lo}, 64'd0);
    chk({tag, "_alu"}, {alu_op1, alu_op2}, 64'd0);
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] va, vb, elo, ehi;
    logic        edbz;
  } vec_t;

  initial begin
    int c0, nb, ne, nm;
    vec_t vecs[$];

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Unsigned multiply of all-ones: timing, busy length and mode.
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33, c0);
    watch(36, nb, ne, nm);
    chk("mul_busy_cycles", 64'(nb), 64'd32);
    chk("mul_alu_en_cycles", 64'(ne), 64'd32);
    chk("mul_mode_not_add", 64'(nm), 64'd0);
    wait_idle();

    // Directed unsigned vectors.
    vecs.push_back('{2'b01, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0});
    vecs.push_back('{2'b01, 32'd7, 32'd7, 32'd1, 32'd0, 1'b0});
    vecs.push_back('{2'b01, 32'd1000, 32'd1001, 32'd0, 32'd1000, 1'b0});
    vecs.push_back('{2'b00, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1'b0});
    vecs.push_back('{2'b00, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0});
    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].va, vecs[i].vb, 1'b1, vecs[i].elo, vecs[i].ehi, vecs[i].edbz, 33, c0);
      wait_idle();
    end

    // Divide by zero: done in cycle 1, ALU never requested.
    issue(2'b01, 32'd55, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd55, 1'b1, 1, c0);
    watch(4, nb, ne, nm);
    chk("div0_alu_en_cycles", 64'(ne), 64'd0);
    chk("div0_busy_cycles", 64'(nb), 64'd0);
    wait_idle();

    // div_by_zero must clear on the next accept.
    issue(2'b01, 32'd9, 32'd4, 1'b1, 32'd2, 32'd1, 1'b0, 33, c0);
    wait_idle();

    // Start while busy is ignored.
    issue(2'b00, 32'd6, 32'd7, 1'b1, 32'd42, 32'd0, 1'b0, 33, c0);
    while (cyc < c0 + 10) @(negedge clk);
    op = 2'b01; a = 32'd50; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    // Reset in cycle 15 of a divide aborts it with no done.
    issue(2'b01, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 33, c0);
    while (cyc < c0 + 15) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("midop_reset");
    repeat (40) @(negedge clk);
    issue(2'b00, 32'd9, 32'd9, 1'b1, 32'd81, 32'd0, 1'b0, 33, c0);
    wait_idle();

`ifdef SIGNED_OPS_EN
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, c0);
    wait_idle();
    issue(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 34, c0);
    wait_idle();
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34, c0);
    wait_idle();
    issue(2'b11, 32'hFFFF_FFF7, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1, 1, c0);
    wait_idle();
`endif

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("done_count", 64'(n_done), 64'(n_pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
